// File: rtl/cpu_sequencer.sv
// cpu_sequencer: 8-phase instruction sequencer for the accumulator CPU.
// Steps through address/fetch/decode/execute phases, inserts MEM_LAT wait
// cycles on memory fetch phases and decodes the memory, IR, accumulator and
// program-counter strobes from the phase, opcode and zero flag.
// Optional feature macro: CTRL_HALT_STOP_EN (HLT freezes the sequencer until
// resume is pulsed). Without it, HLT only raises a one-phase halt flag.
module cpu_sequencer #(
    parameter int MEM_LAT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       resume,
    output logic [2:0] phase,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       load_ac,
    output logic       mem_wr,
    output logic       halt
);

`ifdef CTRL_HALT_STOP_EN
    localparam bit HALT_STOP = 1'b1;
`else
    localparam bit HALT_STOP = 1'b0;
`endif

    localparam int WAIT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_LAT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    phase_e            phase_q, phase_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              halted_q, halted_d;

    logic isHlt, isSkz, isSto, isJmp, aluOp;

    // Opcode classification used by both the sequencing and the strobe decode
    always_comb begin
        isHlt = (opcode == OP_HLT);
        isSkz = (opcode == OP_SKZ);
        isSto = (opcode == OP_STO);
        isJmp = (opcode == OP_JMP);
        aluOp = (opcode == OP_ADD) || (opcode == OP_AND) ||
                (opcode == OP_XOR) || (opcode == OP_LDA);
    end

    // State register: phase, memory wait counter and halted flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            wait_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            wait_q   <= wait_d;
            halted_q <= halted_d;
        end
    end

    // Next state: a halted sequencer only listens to resume; otherwise an
    // enabled cycle either burns a wait count or moves to the next phase,
    // arming the wait counter when a memory fetch phase is entered
    always_comb begin
        phase_d  = phase_q;
        wait_d   = wait_q;
        halted_d = halted_q;
        if (HALT_STOP && halted_q) begin
            if (resume) begin
                halted_d = 1'b0;
            end
        end else if (en) begin
            if (wait_q != '0) begin
                wait_d = wait_q - WAIT_ONE;
            end else if (HALT_STOP && (phase_q == OP_ADDR) && isHlt) begin
                phase_d  = OP_FETCH;
                halted_d = 1'b1;
            end else begin
                phase_d = phase_e'(phase_q + 3'd1);
                if ((phase_d == INST_FETCH) || ((phase_d == OP_FETCH) && aluOp)) begin
                    wait_d = WAIT_LOAD;
                end
            end
        end
    end

    // Strobe decode from the registered phase; everything but mem_rd and
    // halt is qualified by en so a frozen cycle never acts on PC, IR or AC
    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        inc_pc  = 1'b0;
        load_pc = 1'b0;
        load_ac = 1'b0;
        mem_wr  = 1'b0;
        halt    = 1'b0;
        if (HALT_STOP && halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: begin
                end
                INST_FETCH: begin
                    mem_rd = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = en;
                end
                OP_ADDR: begin
                    inc_pc = en;
                    halt   = isHlt;
                end
                OP_FETCH: begin
                    mem_rd = aluOp;
                end
                ALU_OP: begin
                    mem_rd  = aluOp;
                    load_ac = en & aluOp;
                    inc_pc  = en & isSkz & zero;
                    load_pc = en & isJmp;
                end
                STORE: begin
                    load_ac = en & aluOp;
                    mem_wr  = en & isSto;
                    load_pc = en & isJmp;
                end
                default: begin
                end
            endcase
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and randomized checks of cpu_sequencer.
// Two instances (MEM_LAT=0 and MEM_LAT=2) share the stimulus; each is
// compared every cycle against a dwell-time reference model.
// Honours CTRL_HALT_STOP_EN in the same way as the design.
module tb_cpu_sequencer;

`ifdef CTRL_HALT_STOP_EN
    localparam bit HALT_STOP = 1'b1;
`else
    localparam bit HALT_STOP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] opcode;
    logic       zero;
    logic       resume;

    logic [2:0] phase0, phase2;
    logic       memRd0, loadIr0, incPc0, loadPc0, loadAc0, memWr0, halt0;
    logic       memRd2, loadIr2, incPc2, loadPc2, loadAc2, memWr2, halt2;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    int ph0, dwell0, ph2, dwell2;
    bit halted0, halted2;

    cpu_sequencer #(.MEM_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .zero(zero), .resume(resume),
        .phase(phase0), .mem_rd(memRd0), .load_ir(loadIr0), .inc_pc(incPc0),
        .load_pc(loadPc0), .load_ac(loadAc0), .mem_wr(memWr0), .halt(halt0)
    );

    cpu_sequencer #(.MEM_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .zero(zero), .resume(resume),
        .phase(phase2), .mem_rd(memRd2), .load_ir(loadIr2), .inc_pc(incPc2),
        .load_pc(loadPc2), .load_ac(loadAc2), .mem_wr(memWr2), .halt(halt2)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit isAlu(input logic [2:0] op);
        return (op >= 3'd2) && (op <= 3'd5);
    endfunction

    // Expected {phase, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, halt}
    function automatic logic [9:0] expVec(input int ph, input bit halted);
        logic rd, ir, inc, ld, ac, wr, hl;
        bit   alu;
        alu = isAlu(opcode);
        rd = 0; ir = 0; inc = 0; ld = 0; ac = 0; wr = 0; hl = 0;
        if (halted) begin
            hl = 1;
        end else begin
            rd  = (ph == 1) || (ph == 2) || (ph == 3) || (((ph == 5) || (ph == 6)) && alu);
            ir  = en && ((ph == 2) || (ph == 3));
            inc = en && ((ph == 4) || ((ph == 6) && (opcode == 3'd1) && zero));
            ld  = en && ((ph == 6) || (ph == 7)) && (opcode == 3'd7);
            ac  = en && ((ph == 6) || (ph == 7)) && alu;
            wr  = en && (ph == 7) && (opcode == 3'd6);
            hl  = (ph == 4) && (opcode == 3'd0);
        end
        return {3'(ph), rd, ir, inc, ld, ac, wr, hl};
    endfunction

    task automatic resetModels();
        ph0 = 0; dwell0 = 1; halted0 = 0;
        ph2 = 0; dwell2 = 1; halted2 = 0;
    endtask

    // One clock edge of the reference: a phase is occupied for a number of
    // enabled cycles (1, or 1+latency on a memory fetch), then advances
    task automatic modelEdge(input int lat, inout int ph, inout int dwell, inout bit halted);
        if (rst) begin
            ph = 0; dwell = 1; halted = 0;
        end else if (HALT_STOP && halted) begin
            if (resume) halted = 0;
        end else if (en) begin
            if (HALT_STOP && (ph == 4) && (opcode == 3'd0)) begin
                ph = 5; dwell = 1; halted = 1;
            end else begin
                dwell = dwell - 1;
                if (dwell == 0) begin
                    ph = (ph + 1) % 8;
                    dwell = ((ph == 1) || ((ph == 5) && isAlu(opcode))) ? lat + 1 : 1;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b", tag, cycle, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, check both instances mid-cycle, then
    // advance the models across the following rising edge
    task automatic applyStimulus(input bit e, input logic [2:0] op, input bit z, input bit res, input bit r);
        en = e; opcode = op; zero = z; resume = res; rst = r;
        if (r) resetModels();
        @(negedge clk);
        checkOutput("lat0", {phase0, memRd0, loadIr0, incPc0, loadPc0, loadAc0, memWr0, halt0},
                    expVec(ph0, halted0));
        checkOutput("lat2", {phase2, memRd2, loadIr2, incPc2, loadPc2, loadAc2, memWr2, halt2},
                    expVec(ph2, halted2));
        @(posedge clk);
        modelEdge(0, ph0, dwell0, halted0);
        modelEdge(2, ph2, dwell2, halted2);
        cycle++;
        #1;
    endtask

    task automatic runOp(input int n, input logic [2:0] op, input bit z);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, op, z, 1'b0, 1'b0);
    endtask

    // Directed steps followed by a randomized run
    initial begin
        rst = 1'b1; en = 1'b0; opcode = 3'd2; zero = 1'b0; resume = 1'b0;
        resetModels();

        $display("[TB] reset and ADD sequence");
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        runOp(20, 3'd2, 1'b0);

        $display("[TB] SKZ, JMP, STO");
        runOp(16, 3'd1, 1'b1);
        runOp(16, 3'd1, 1'b0);
        runOp(16, 3'd7, 1'b1);
        runOp(16, 3'd6, 1'b0);

        $display("[TB] en=0 in OP_ADDR");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(ph0 == 4 ? 1'b0 : 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] HLT and resume");
        runOp(20, 3'd0, 1'b0);
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        runOp(12, 3'd0, 1'b0);
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        runOp(6, 3'd3, 1'b0);

        $display("[TB] asynchronous reset in phase 6");
        for (int i = 0; i < 24 && ph0 != 6; i++) applyStimulus(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        checkOutput("reach_phase6", {7'd0, phase0}, 10'd6);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_lat0", {phase0, memRd0, loadIr0, incPc0, loadPc0, loadAc0, memWr0, halt0}, 10'd0);
        checkOutput("async_rst_lat2", {phase2, memRd2, loadIr2, incPc2, loadPc2, loadAc2, memWr2, halt2}, 10'd0);
        resetModels();
        @(posedge clk);
        #1;
        runOp(10, 3'd2, 1'b0);

        $display("[TB] randomized run");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
